if_fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. It owns the program counter and selects the next PC from sequential, branch, jump and jump-register sources. It fetches from an instruction memory port that may insert wait states, and holds a fetched word while the pipeline is stalled. It delivers `is`, `pc_plus4F` and a validity flag; the hazard unit combines that flag with redirects to drive the IF/ID flush.

---
 rtl/if_fetch_unit.sv | 112 +++++++++++
 tb/tb_if_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, selects next-PC sources and
// holds a fetched word across pipeline stalls.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_adr,
    input  logic [31:0] jump_pc4,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] is,
    output logic        is_valid,
    output logic [31:0] pc_plus4F,
    output logic        fetch_wait
);

    typedef enum logic {
        S_FETCH,
        S_HOLD
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] pc_nx;
    logic [31:0] hold_buf;
    logic [31:0] hold_nx;
    logic [31:0] pc_seq;
    logic [31:0] target;
    logic        redirect;

    assign pc_seq    = pc + 32'd4;
    assign pc_plus4F = pc_seq;
    assign imem_addr = pc;
    assign redirect  = pc_write & (jr | jump | branch_taken);

    always_comb begin
        target = pc_seq;
        priority case (1'b1)
            jr:           target = jr_target;
            jump:         target = {jump_pc4[31:28], jump_adr, 2'b00};
            branch_taken: target = branch_target;
            default:      target = pc_seq;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            hold_buf <= 32'h0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            hold_buf <= hold_nx;
        end
    end

    // Outputs are forced quiet while reset is held, independent of state.
    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        hold_nx    = hold_buf;
        imem_req   = 1'b0;
        is         = 32'h0;
        is_valid   = 1'b0;
        fetch_wait = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (redirect) begin
                        pc_nx = target;
                    end else if (imem_ready) begin
                        is       = imem_rdata;
                        is_valid = 1'b1;
                        if (pc_write) begin
                            pc_nx = pc_seq;
                        end else begin
                            hold_nx  = imem_rdata;
                            state_nx = S_HOLD;
                        end
                    end else begin
                        fetch_wait = 1'b1;
                    end
                end
                S_HOLD: begin
                    is       = hold_buf;
                    is_valid = 1'b1;
                    if (redirect) begin
                        pc_nx    = target;
                        state_nx = S_FETCH;
                    end else if (pc_write) begin
                        pc_nx    = pc_seq;
                        state_nx = S_FETCH;
                    end
                end
                default: state_nx = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed-vector bench for if_fetch_unit with a combinational
// instruction memory whose word is derived from the address.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_adr;
    logic [31:0] jump_pc4;
    logic        jr;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] is;
    logic        is_valid;
    logic [31:0] pc_plus4F;
    logic        fetch_wait;
    logic [31:0] rd_xor;

    int total;
    int bad;

    if_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_adr      (jump_adr),
        .jump_pc4      (jump_pc4),
        .jr            (jr),
        .jr_target     (jr_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .is            (is),
        .is_valid      (is_valid),
        .pc_plus4F     (pc_plus4F),
        .fetch_wait    (fetch_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // rd_xor corrupts the memory word so held data can be told apart
    assign imem_rdata = word(imem_addr) ^ rd_xor;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        pc_write = 1'b1;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        jump = 1'b0;
        jump_adr = 26'h0;
        jump_pc4 = 32'h0;
        jr = 1'b0;
        jr_target = 32'h0;
        imem_ready = 1'b1;
        rd_xor = 32'h0;

        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", is_valid, 0);
        chk("rst_is", is, 0);
        chk("rst_wait", fetch_wait, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc4", pc_plus4F, 32'h4);
        @(posedge clk);

        step(); reset = 1'b0; #1;
        chk("seq0_req", imem_req, 1);
        chk("seq0_addr", imem_addr, 32'h0);
        chk("seq0_valid", is_valid, 1);
        chk("seq0_is", is, word(32'h0));
        chk("seq0_pc4", pc_plus4F, 32'h4);

        step(); #1;
        chk("seq1_addr", imem_addr, 32'h4);
        chk("seq1_valid", is_valid, 1);
        chk("seq1_pc4", pc_plus4F, 32'h8);

        step(); imem_ready = 1'b0; #1;
        chk("w0_addr", imem_addr, 32'h8);
        chk("w0_pc4", pc_plus4F, 32'hC);
        chk("w0_wait", fetch_wait, 1);
        chk("w0_valid", is_valid, 0);
        chk("w0_is", is, 0);

        step(); #1;
        chk("w1_addr", imem_addr, 32'h8);
        chk("w1_wait", fetch_wait, 1);
        chk("w1_valid", is_valid, 0);

        step(); imem_ready = 1'b1; #1;
        chk("w2_valid", is_valid, 1);
        chk("w2_is", is, word(32'h8));
        chk("w2_wait", fetch_wait, 0);

        step(); #1;
        chk("w3_addr", imem_addr, 32'hC);

        step(); pc_write = 1'b0; #1;
        chk("h0_addr", imem_addr, 32'h10);
        chk("h0_req", imem_req, 1);
        chk("h0_valid", is_valid, 1);
        chk("h0_is", is, word(32'h10));

        step(); rd_xor = 32'hFFFF_FFFF; #1;
        chk("h1_req", imem_req, 0);
        chk("h1_valid", is_valid, 1);
        chk("h1_is", is, word(32'h10));

        step(); branch_taken = 1'b1; branch_target = 32'h200; #1;
        chk("h2_req", imem_req, 0);
        chk("h2_is", is, word(32'h10));

        step(); branch_taken = 1'b0; #1;
        chk("h3_addr", imem_addr, 32'h10);
        chk("h3_req", imem_req, 0);
        chk("h3_is", is, word(32'h10));

        step(); pc_write = 1'b1; branch_taken = 1'b1; #1;
        chk("h4_valid", is_valid, 1);
        chk("h4_is", is, word(32'h10));

        step(); branch_taken = 1'b0; rd_xor = 32'h0; #1;
        chk("br_addr", imem_addr, 32'h200);
        chk("br_req", imem_req, 1);

        step();
        jr = 1'b1; jr_target = 32'h400;
        jump = 1'b1; jump_adr = 26'h40; jump_pc4 = 32'h1000_0004;
        branch_taken = 1'b1; branch_target = 32'h200;
        #1;
        chk("pri3_valid", is_valid, 0);
        chk("pri3_is", is, 0);

        step(); jr = 1'b0; jump = 1'b0; branch_taken = 1'b0; #1;
        chk("pri3_addr", imem_addr, 32'h400);
        chk("pri3_nvalid", is_valid, 1);

        step(); jump = 1'b1; branch_taken = 1'b1; #1;
        chk("pri2_valid", is_valid, 0);

        step(); jump = 1'b0; branch_taken = 1'b0; #1;
        chk("pri2_addr", imem_addr, 32'h1000_0100);

        step(); jr = 1'b1; jr_target = 32'hFFFF_FFFC; #1;
        chk("wr0_valid", is_valid, 0);

        step(); jr = 1'b0; #1;
        chk("wr1_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wr1_pc4", pc_plus4F, 32'h0);

        step(); #1;
        chk("wr2_addr", imem_addr, 32'h0);

        step(); #1;
        chk("ar0_addr", imem_addr, 32'h4);

        step(); pc_write = 1'b0; #1;
        chk("ar1_valid", is_valid, 1);

        step(); #1;
        chk("ar2_req", imem_req, 0);
        chk("ar2_valid", is_valid, 1);
        #1; reset = 1'b1; #1;
        chk("ar3_valid", is_valid, 0);
        chk("ar3_is", is, 0);
        chk("ar3_addr", imem_addr, 32'h0);
        chk("ar3_pc4", pc_plus4F, 32'h4);

        step(); reset = 1'b0; pc_write = 1'b1; #1;
        chk("ar4_req", imem_req, 1);
        chk("ar4_is", is, word(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
